// File: rtl/cyclic_alloc_tracker.sv
// In-order allocation tracker for a circular buffer: tail allocation, out-of-order
// completion by absolute index, in-order retirement from the head.
module cyclic_alloc_tracker #(
  parameter int LOG_DEPTH = 3,
  localparam int DEPTH = 1 << LOG_DEPTH
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 pushReq,
  output logic                 pushReady,
  output logic [LOG_DEPTH-1:0] pushIdx,
  input  logic                 completeValid,
  input  logic [LOG_DEPTH-1:0] completeIdx,
  input  logic                 popReq,
  output logic                 popValid,
  output logic [LOG_DEPTH-1:0] popIdx,
  input  logic                 flush,
  output logic [DEPTH-1:0]     validMask,
  output logic [DEPTH-1:0]     doneMask,
  output logic [LOG_DEPTH:0]   count,
  output logic                 full,
  output logic                 empty
);

  // Pointers carry one extra MSB as the wrap bit; a plain +1 toggles it on rollover.
  logic [LOG_DEPTH:0]   headPtr;
  logic [LOG_DEPTH:0]   tailPtr;
  logic [LOG_DEPTH-1:0] headIdx;
  logic [LOG_DEPTH-1:0] tailIdx;
  logic                 pushFire;
  logic                 popFire;
  logic                 completeFire;
  logic [DEPTH-1:0]     validNext;
  logic [DEPTH-1:0]     doneNext;
  logic [LOG_DEPTH:0]   countNext;
  logic [DEPTH-1:0]     rangeMask;

  assign headIdx = headPtr[LOG_DEPTH-1:0];
  assign tailIdx = tailPtr[LOG_DEPTH-1:0];

  assign full      = (headIdx == tailIdx) && (headPtr[LOG_DEPTH] != tailPtr[LOG_DEPTH]);
  assign empty     = (headIdx == tailIdx) && (headPtr[LOG_DEPTH] == tailPtr[LOG_DEPTH]);
  assign pushReady = !full;
  assign pushIdx   = tailIdx;
  assign popIdx    = headIdx;
  assign popValid  = validMask[headIdx] && doneMask[headIdx];

  assign pushFire     = pushReq && !full;
  assign popFire      = popReq && popValid;
  assign completeFire = completeValid && validMask[completeIdx];

  // Push and pop never target the same slot: push needs !full, pop needs !empty.
  always_comb begin
    validNext = validMask;
    doneNext  = doneMask;
    if (completeFire) doneNext[completeIdx] = 1'b1;
    if (popFire) begin
      validNext[headIdx] = 1'b0;
      doneNext[headIdx]  = 1'b0;
    end
    if (pushFire) begin
      validNext[tailIdx] = 1'b1;
      doneNext[tailIdx]  = 1'b0;
    end
    countNext = count + (LOG_DEPTH+1)'(pushFire) - (LOG_DEPTH+1)'(popFire);
  end

  always_ff @(posedge clk) begin
    if (!resetN || flush) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      validMask <= '0;
      doneMask  <= '0;
      count     <= '0;
    end else begin
      if (pushFire) tailPtr <= tailPtr + 1'b1;
      if (popFire)  headPtr <= headPtr + 1'b1;
      validMask <= validNext;
      doneMask  <= doneNext;
      count     <= countNext;
    end
  end

  // Expected occupancy: slots whose distance from head is below count.
  always_comb begin
    rangeMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rangeMask[i] = ({1'b0, LOG_DEPTH'(i) - headIdx} < count);
    end
  end

  validRangeA: assert property (@(posedge clk) disable iff (!resetN) validMask == rangeMask);
  doneSubsetA: assert property (@(posedge clk) disable iff (!resetN) (doneMask & ~validMask) == '0);
  fullCountA:  assert property (@(posedge clk) disable iff (!resetN)
                                full == (count == (LOG_DEPTH+1)'(DEPTH)));
  emptyCountA: assert property (@(posedge clk) disable iff (!resetN) empty == (count == '0));

endmodule

// File: tb/tb_cyclic_alloc_tracker.sv
// Bench for cyclic_alloc_tracker: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_cyclic_alloc_tracker;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       pushReq = 1'b0;
  logic       completeValid = 1'b0;
  logic [2:0] completeIdx = '0;
  logic       popReq = 1'b0;
  logic       flush = 1'b0;
  logic       pushReady;
  logic [2:0] pushIdx;
  logic       popValid;
  logic [2:0] popIdx;
  logic [7:0] validMask;
  logic [7:0] doneMask;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  cyclic_alloc_tracker #(.LOG_DEPTH(3)) dut (
    .clk(clk), .resetN(resetN), .pushReq(pushReq), .pushReady(pushReady), .pushIdx(pushIdx),
    .completeValid(completeValid), .completeIdx(completeIdx), .popReq(popReq),
    .popValid(popValid), .popIdx(popIdx), .flush(flush), .validMask(validMask),
    .doneMask(doneMask), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of live entries (done flags), oldest first.
  bit mq[$];
  int mHead = 0;

  function automatic void modelUpdate(input logic rN, pu, cv, input logic [2:0] ci,
                                      input logic po, fl);
    bit canPop;
    bit canPush;
    int k;
    if (!rN || fl) begin
      mq.delete();
      mHead = 0;
      return;
    end
    canPop  = (mq.size() > 0) && mq[0];
    canPush = mq.size() < 8;
    if (cv) begin
      k = (int'(ci) - mHead + 8) % 8;
      if (k < mq.size()) mq[k] = 1'b1;
    end
    if (po && canPop) begin
      void'(mq.pop_front());
      mHead = (mHead + 1) % 8;
    end
    if (pu && canPush) mq.push_back(1'b0);
  endfunction

  function automatic logic [7:0] mValid();
    logic [7:0] m = '0;
    for (int k = 0; k < mq.size(); k++) m[(mHead + k) % 8] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] mDone();
    logic [7:0] m = '0;
    for (int k = 0; k < mq.size(); k++) if (mq[k]) m[(mHead + k) % 8] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    chk({tag, " count"}, 32'(count), 32'(mq.size()));
    chk({tag, " validMask"}, 32'(validMask), 32'(mValid()));
    chk({tag, " doneMask"}, 32'(doneMask), 32'(mDone()));
    chk({tag, " popValid"}, 32'(popValid), 32'((mq.size() > 0) && mq[0]));
    chk({tag, " full"}, 32'(full), 32'(mq.size() == 8));
    chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, " pushReady"}, 32'(pushReady), 32'(mq.size() != 8));
    chk({tag, " pushIdx"}, 32'(pushIdx), 32'((mHead + mq.size()) % 8));
    chk({tag, " popIdx"}, 32'(popIdx), 32'(mHead));
  endtask

  task automatic step(input string tag, input logic rN, pu, cv, input logic [2:0] ci,
                      input logic po, fl);
    resetN = rN; pushReq = pu; completeValid = cv; completeIdx = ci; popReq = po; flush = fl;
    @(posedge clk);
    modelUpdate(rN, pu, cv, ci, po, fl);
    #1;
    checkModel(tag);
  endtask

  typedef struct {
    logic       rN, pu, cv;
    logic [2:0] ci;
    logic       po, fl;
    logic [3:0] eCnt;
    logic [7:0] eValid, eDone;
    logic       ePopValid, eFull;
    logic [2:0] ePushIdx, ePopIdx;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0};
    for (int k = 1; k <= 8; k++)
      vecs[k] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'(k), 8'((1 << k) - 1), 8'h00,
                  1'b0, (k == 8), 3'(k % 8), 3'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd8, 8'hFF, 8'h00, 1'b0, 1'b1, 3'd0, 3'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 4'd8, 8'hFF, 8'h04, 1'b0, 1'b1, 3'd0, 3'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd8, 8'hFF, 8'h05, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 4'd7, 8'hFE, 8'h04, 1'b0, 1'b0, 3'd0, 3'd1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd7, 8'hFE, 8'h06, 1'b1, 1'b0, 3'd0, 3'd1};

    // Fill, overflow attempt, out-of-order completion and first pop.
    for (int v = 0; v < 14; v++) begin
      step($sformatf("vec%0d", v), vecs[v].rN, vecs[v].pu, vecs[v].cv, vecs[v].ci,
           vecs[v].po, vecs[v].fl);
      chk($sformatf("vec%0d tbl count", v), 32'(count), 32'(vecs[v].eCnt));
      chk($sformatf("vec%0d tbl validMask", v), 32'(validMask), 32'(vecs[v].eValid));
      chk($sformatf("vec%0d tbl doneMask", v), 32'(doneMask), 32'(vecs[v].eDone));
      chk($sformatf("vec%0d tbl popValid", v), 32'(popValid), 32'(vecs[v].ePopValid));
      chk($sformatf("vec%0d tbl full", v), 32'(full), 32'(vecs[v].eFull));
      chk($sformatf("vec%0d tbl pushIdx", v), 32'(pushIdx), 32'(vecs[v].ePushIdx));
      chk($sformatf("vec%0d tbl popIdx", v), 32'(popIdx), 32'(vecs[v].ePopIdx));
    end

    // Wrap-around: push 8, complete and pop 5, push 4.
    step("wrapRst", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step("wrapPush", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step("wrapCpl", 1'b1, 1'b0, 1'b1, 3'(k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step("wrapPop", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step("wrapPush2", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("wrap pushIdx", 32'(pushIdx), 32'd4);
    chk("wrap popIdx", 32'(popIdx), 32'd5);
    chk("wrap validMask", 32'(validMask), 32'hEF);
    chk("wrap count", 32'(count), 32'd7);

    // Full: push+pop accepts only the pop.
    step("fullCpl", 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    step("fullPush", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("full flag", 32'(full), 32'd1);
    step("fullPushPop", 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("fullPushPop count", 32'(count), 32'd7);
    chk("fullPushPop pushIdx", 32'(pushIdx), 32'd5);
    chk("fullPushPop popIdx", 32'(popIdx), 32'd6);

    // Flush beats everything; stale completion afterwards is ignored.
    step("flush", 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
    chk("flush count", 32'(count), 32'd0);
    chk("flush validMask", 32'(validMask), 32'd0);
    chk("flush empty", 32'(empty), 32'd1);
    step("staleCpl", 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    chk("staleCpl doneMask", 32'(doneMask), 32'd0);

    // Push+pop at count 3.
    for (int k = 0; k < 3; k++) step("c3Push", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step("c3Cpl", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    step("c3PushPop", 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("c3 count", 32'(count), 32'd3);
    chk("c3 popIdx", 32'(popIdx), 32'd1);
    chk("c3 pushIdx", 32'(pushIdx), 32'd4);

    // Same-cycle push and complete of an empty slot: earliest pop two cycles later.
    step("pcRst", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step("pcBoth", 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("pcBoth popValid", 32'(popValid), 32'd0);
    chk("pcBoth doneMask", 32'(doneMask), 32'd0);
    step("pcCpl", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("pcCpl popValid", 32'(popValid), 32'd1);
    step("pcPop", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("pcPop empty", 32'(empty), 32'd1);

    // Reset mid-stream with 5 entries, 2 done.
    for (int k = 0; k < 5; k++) step("mrPush", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step("mrCpl", 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    step("mrCpl", 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    chk("mr doneMask", 32'(doneMask), 32'h14);
    step("mrRst", 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
    chk("mrRst count", 32'(count), 32'd0);
    chk("mrRst validMask", 32'(validMask), 32'd0);
    chk("mrRst pushIdx", 32'(pushIdx), 32'd0);
    chk("mrRst pushReady", 32'(pushReady), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step("rand",
           1'($urandom_range(0, 299) != 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) == 0 ? 1 : $urandom_range(0, 1)),
           1'($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
